// File: rtl/ppm_pkg.sv
// Shared PPM line definitions used by both the transmit and receive chains.
package ppm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_DATA = 3'd2,
    ST_EOF  = 3'd3,
    ST_GAP  = 3'd4
  } ppm_state_t;

  // Bit i is the line level of slot i (0 = pulse).
  localparam logic [7:0] SOF_PATTERN = 8'b1101_1110;
  localparam logic [3:0] EOF_PATTERN = 4'b1011;

  localparam int unsigned SLOTS_PER_SYM = 8;
  localparam int unsigned SOF_SLOTS     = 8;
  localparam int unsigned EOF_SLOTS     = 4;

  // A data symbol of value v pulses low in slot 2v+1.
  function automatic logic data_level(input logic [2:0] slot, input logic [1:0] v);
    return (slot != {v, 1'b1});
  endfunction

endpackage

// File: rtl/ppm_sym_map.sv
// Combinational slot-level lookup: line level for a given state, slot and symbol value.
import ppm_pkg::*;

module ppm_sym_map (
  input  ppm_state_t state,
  input  logic [2:0] slot,
  input  logic [1:0] sym,
  output logic       level
);

  always_comb begin
    level = 1'b1;
    case (state)
      ST_SOF:  level = SOF_PATTERN[slot];
      ST_DATA: level = data_level(slot, sym);
      ST_EOF:  level = EOF_PATTERN[slot[1:0]];
      default: level = 1'b1;
    endcase
  end

endmodule

// File: rtl/ppm_frame_tx.sv
// PPM frame transmitter: byte stream in, SOF / 1-of-4 data symbols / EOF / gap out on an
// active-low line, advancing one slot per clk16 strobe.
import ppm_pkg::*;

module ppm_frame_tx #(
  parameter int unsigned GAP_SLOTS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk16,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dout,
  output logic       busy,
  output logic       frame_done,
  output logic       tx_underrun
);

  localparam logic [7:0] GAP_LAST  = 8'(GAP_SLOTS - 1);
  localparam logic [2:0] SOF_LAST  = 3'(SOF_SLOTS - 1);
  localparam logic [2:0] SYM_LAST  = 3'(SLOTS_PER_SYM - 1);
  localparam logic [2:0] EOF_LAST  = 3'(EOF_SLOTS - 1);

  ppm_state_t state, nx_state, st_eff;
  logic [2:0] slot, nx_slot;
  logic [1:0] sym_cnt, nx_sym;
  logic [7:0] gap_cnt, shreg, buf_data;
  logic       buf_full, buf_last, cur_last, last_cap;
  logic       accept, lc_nx, ready_nx, level;

  assign accept = tx_valid & tx_ready;

  // Slot sequencer lookahead: where the next clk16 strobe takes us and which symbol it shows.
  always_comb begin
    nx_state = state;
    nx_slot  = slot;
    nx_sym   = shreg[1:0];
    case (state)
      ST_IDLE: begin
        if (buf_full) begin
          nx_state = ST_SOF;
          nx_slot  = 3'd0;
        end else begin
          nx_state = ST_IDLE;
        end
      end
      ST_SOF: begin
        if (slot == SOF_LAST) begin
          nx_state = ST_DATA;
          nx_slot  = 3'd0;
          nx_sym   = buf_data[1:0];
        end else begin
          nx_slot = slot + 3'd1;
        end
      end
      ST_DATA: begin
        if (slot != SYM_LAST) begin
          nx_slot = slot + 3'd1;
        end else if (sym_cnt != 2'd3) begin
          nx_slot = 3'd0;
          nx_sym  = shreg[3:2];
        end else if (!cur_last && buf_full) begin
          nx_slot = 3'd0;
          nx_sym  = buf_data[1:0];
        end else begin
          nx_state = ST_EOF;
          nx_slot  = 3'd0;
        end
      end
      ST_EOF: begin
        if (slot == EOF_LAST) begin
          nx_state = ST_GAP;
          nx_slot  = 3'd0;
        end else begin
          nx_slot = slot + 3'd1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          nx_state = ST_IDLE;
        end else begin
          nx_state = ST_GAP;
        end
      end
      default: begin
        nx_state = ST_IDLE;
        nx_slot  = 3'd0;
      end
    endcase
  end

  ppm_sym_map u_sym_map (
    .state (nx_state),
    .slot  (nx_slot),
    .sym   (nx_sym),
    .level (level)
  );

  // Ready looks at post-edge state so it never lingers into EOF nor lags the return to IDLE.
  always_comb begin
    st_eff   = clk16 ? nx_state : state;
    lc_nx    = (clk16 && (state == ST_GAP) && (nx_state == ST_IDLE)) ? 1'b0 : last_cap;
    ready_nx = !accept && !buf_full && !lc_nx &&
               ((st_eff == ST_IDLE) || (st_eff == ST_SOF) || (st_eff == ST_DATA));
  end

  // Control FSM, counters, holding buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      slot        <= 3'd0;
      sym_cnt     <= 2'd0;
      gap_cnt     <= 8'd0;
      shreg       <= 8'd0;
      cur_last    <= 1'b0;
      buf_data    <= 8'd0;
      buf_last    <= 1'b0;
      buf_full    <= 1'b0;
      last_cap    <= 1'b0;
      tx_ready    <= 1'b0;
      dout        <= 1'b1;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      tx_underrun <= 1'b0;
      tx_ready    <= ready_nx;
      if (accept) begin
        buf_data <= tx_data;
        buf_last <= tx_last;
        buf_full <= 1'b1;
        busy     <= 1'b1;
        if (tx_last) last_cap <= 1'b1;
      end
      if (clk16) begin
        state <= nx_state;
        slot  <= nx_slot;
        dout  <= level;
        case (state)
          ST_IDLE: if (buf_full) busy <= 1'b1;
          ST_SOF: begin
            if (slot == SOF_LAST) begin
              shreg    <= buf_data;
              cur_last <= buf_last;
              buf_full <= 1'b0;
              sym_cnt  <= 2'd0;
              if (buf_last) last_cap <= 1'b1;
            end
          end
          ST_DATA: begin
            if (slot == SYM_LAST) begin
              if (sym_cnt != 2'd3) begin
                sym_cnt <= sym_cnt + 2'd1;
                shreg   <= {2'b00, shreg[7:2]};
              end else if (!cur_last && buf_full) begin
                shreg    <= buf_data;
                cur_last <= buf_last;
                buf_full <= 1'b0;
                sym_cnt  <= 2'd0;
                if (buf_last) last_cap <= 1'b1;
              end else if (!cur_last) begin
                tx_underrun <= 1'b1;
              end
            end
          end
          ST_EOF: begin
            if (slot == EOF_LAST) begin
              frame_done <= 1'b1;
              gap_cnt    <= 8'd0;
            end
          end
          ST_GAP: begin
            gap_cnt <= gap_cnt + 8'd1;
            if (gap_cnt == GAP_LAST) begin
              busy     <= 1'b0;
              last_cap <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
